// File: rtl/instruction_encode.sv
// instruction_encode
//   Packs decoded RV32I fields back into 32-bit instruction words. Each
//   accepted bundle with a supported opcode is written one cycle later to
//   the next consecutive word of a single-port instruction memory.
//   Unsupported opcodes are consumed and flagged on err / err_opcode.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 clears the write pointer (count); err_opcode kept
//   in_valid / in_ready   field-bundle handshake; in_ready = !full && !flush
//   opcode, rd, rs1, rs2, func3, func7, imm   decoded instruction fields
//   mem_we, mem_addr, mem_data                registered memory write port
//   count, full           words written since reset/flush; count == DEPTH
//   err, err_opcode       one-cycle unsupported-opcode pulse and its opcode
module instruction_encode #(
   parameter int          DEPTH_LOG2 = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            func3,
   input  logic [6:0]            func7,
   input  logic [31:0]           imm,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  err,
   output logic [6:0]            err_opcode
);

   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_I_LOAD = 7'b0000011;
   localparam logic [6:0] OP_I_JALR = 7'b1100111;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_U_LUI  = 7'b0110111;
   localparam logic [6:0] OP_U_AUI  = 7'b0010111;
   localparam logic [6:0] OP_J      = 7'b1101111;

   function automatic logic is_supported(input logic [6:0] op);
      case (op)
         OP_R, OP_I_ALU, OP_I_LOAD, OP_I_JALR, OP_S, OP_B,
         OP_U_LUI, OP_U_AUI, OP_J: is_supported = 1'b1;
         default:                  is_supported = 1'b0;
      endcase
   endfunction

   // Fields are placed verbatim; imm[0] of B/J formats is not encodable.
   function automatic logic [31:0] encode(
      input logic [6:0]  op,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_rs1,
      input logic [4:0]  f_rs2,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [31:0] im
   );
      case (op)
         OP_R:
            encode = {f7, f_rs2, f_rs1, f3, f_rd, op};
         OP_I_ALU, OP_I_LOAD, OP_I_JALR:
            encode = {im[11:0], f_rs1, f3, f_rd, op};
         OP_S:
            encode = {im[11:5], f_rs2, f_rs1, f3, im[4:0], op};
         OP_B:
            encode = {im[12], im[10:5], f_rs2, f_rs1, f3, im[4:1], im[11], op};
         OP_U_LUI, OP_U_AUI:
            encode = {im[31:12], f_rd, op};
         OP_J:
            encode = {im[20], im[10:1], im[11], im[19:12], f_rd, op};
         default:
            encode = 32'h0;
      endcase
   endfunction

   logic          vld_p0;
   logic          sup_p0;
   logic [31:0]   word_p0;
   logic [31:0]   addr_p0;

   logic          we_p1;
   logic [31:0]   addr_p1;
   logic [31:0]   data_p1;
   logic [CW-1:0] count_p1;
   logic          err_p1;
   logic [6:0]    err_op_p1;

   assign full     = (count_p1 == CW'(DEPTH));
   assign in_ready = !full && !flush;

   // Stage 0: handshake, opcode check and word packing
   always_comb begin
      vld_p0  = in_valid && in_ready;
      sup_p0  = is_supported(opcode);
      word_p0 = encode(opcode, rd, rs1, rs2, func3, func7, imm);
      addr_p0 = BASE_ADDR + (32'(count_p1) << 2);
   end

   // Stage 1: registered memory write port, pointer and error flag
   always_ff @(posedge clock) begin
      if (reset) begin
         we_p1     <= 1'b0;
         addr_p1   <= BASE_ADDR;
         data_p1   <= 32'h0;
         count_p1  <= '0;
         err_p1    <= 1'b0;
         err_op_p1 <= 7'h0;
      end else begin
         we_p1  <= 1'b0;
         err_p1 <= 1'b0;
         if (flush) begin
            count_p1 <= '0;
         end else if (vld_p0) begin
            if (sup_p0) begin
               we_p1    <= 1'b1;
               addr_p1  <= addr_p0;
               data_p1  <= word_p0;
               count_p1 <= count_p1 + CW'(1);
            end else begin
               err_p1    <= 1'b1;
               err_op_p1 <= opcode;
            end
         end
      end
   end

   assign mem_we     = we_p1;
   assign mem_addr   = addr_p1;
   assign mem_data   = data_p1;
   assign count      = count_p1;
   assign err        = err_p1;
   assign err_opcode = err_op_p1;

endmodule

// File: doc/instruction_encode.md
Name: instruction_encode

Overview:
Packs decoded RISC-V RV32I instruction fields (opcode, rs1, rs2, rd, func3, func7, imm) back into 32-bit instruction words. Writes each word sequentially into instruction memory at consecutive word addresses. Used as the program loader / self-test generator on the fetch side of the pipeline, producing the words that the decode stage later splits. Valid/ready input handshake, registered single-port memory write output, word counter with full and error flags.

Parameters:
DEPTH_LOG2, 8, log2 of the number of instruction words the target memory holds (DEPTH = 2**DEPTH_LOG2)
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of the write pointer; does not touch err_opcode
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept; = !full && !flush (combinational)
opcode  input  7  instruction opcode [6:0]
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
func3  input  3  funct3
func7  input  7  funct7
imm  input  32  immediate in its decoded (unscrambled) bit positions
mem_we  output  1  write strobe, one cycle per encoded word
mem_addr  output  32  byte address = BASE_ADDR + 4*word index
mem_data  output  32  encoded instruction word
count  output  DEPTH_LOG2+1  number of words written since reset/flush
full  output  1  count == DEPTH
err  output  1  one-cycle pulse: accepted bundle had an unsupported opcode
err_opcode  output  7  opcode of the most recent error; holds until next error or reset

Behaviour:
- Reset: mem_we=0, mem_addr=BASE_ADDR, mem_data=0, count=0, full=0, err=0, err_opcode=0. Reset has priority over everything.
- Accept: in_valid && in_ready at a rising edge. Latency is 1 cycle. On the next cycle the block drives mem_we=1, mem_data=encoded word, mem_addr=BASE_ADDR+4*(count before accept). On the same edge, count increments by 1 and full is updated.
- mem_we is 0 in every cycle that does not follow an accepted, supported bundle. mem_addr and mem_data hold their last values when mem_we=0.
- Encoding (fields taken verbatim; no range checks):
  - R 0110011: func7[31:25] rs2[24:20] rs1[19:15] func3[14:12] rd[11:7] opcode.
  - I 0010011/0000011/1100111: imm[11:0]->[31:20], rs1, func3, rd, opcode. Shift encodings rely on the caller putting func7 in imm[11:5].
  - S 0100011: imm[11:5]->[31:25], rs2, rs1, func3, imm[4:0]->[11:7].
  - B 1100011: imm[12]->31, imm[10:5]->[30:25], rs2, rs1, func3, imm[4:1]->[11:8], imm[11]->7. imm[0] is ignored.
  - U 0110111/0010111: imm[31:12]->[31:12], rd, opcode.
  - J 1101111: imm[20]->31, imm[10:1]->[30:21], imm[11]->20, imm[19:12]->[19:12], rd, opcode. imm[0] is ignored.
- Any other opcode, when accepted:
  - err=1 for exactly the following cycle, err_opcode latched.
  - mem_we=0; count and mem_addr pointer unchanged.
  - The handshake still completes, so the bundle is consumed.
- Full:
  - When count reaches DEPTH, full=1 and in_ready=0.
  - No write beyond the last word; count never exceeds DEPTH and never wraps.
- Flush (takes effect at the edge where flush=1):
  - count=0, full=0, pointer back to BASE_ADDR, mem_we=0 next cycle.
  - in_ready=0 during the flush cycle, so no accept can coincide with a flush.
  - err is not generated by a flush cycle.
- Reset mid-stream: a word accepted in the cycle reset is high is discarded (mem_we=0 next cycle).
- Back-to-back accepts: supported every cycle. Consecutive cycles produce consecutive addresses with no bubbles.

Test Plan:
- After reset, addi x1,x0,5 (opcode 0010011, rd=1, func3=0, rs1=0, imm=5) -> next cycle mem_we=1, mem_addr=0x0, mem_data=0x00500093, count=1.
- Back-to-back:
  - add x3,x1,x2 (func7=0) -> 0x002081B3 @0x0.
  - sw x2,8(x1) -> 0x0020A423 @0x4.
  - beq x1,x2,16 -> 0x00208863 @0x8.
  - lui x5 imm=0x12345000 -> 0x123452B7 @0xC.
  - jal x1 imm=0x800 -> 0x001000EF @0x10.
  - Required: five consecutive mem_we cycles, count=5.
- Unsupported opcode 0x7F -> err=1 for one cycle, err_opcode=0x7F, mem_we=0, count unchanged. The next valid addi is written to the following address.
- DEPTH_LOG2=2, six bundles with in_valid held high -> writes at 0x0, 0x4, 0x8, 0xC only. full=1 and in_ready=0 from the cycle after the 4th accept; count=4 holds.
- Full, then flush pulse -> count=0, full=0, in_ready=1 the next cycle. The next accept writes to BASE_ADDR.
- Reset asserted in the same cycle as an accept, with count=2 -> next cycle mem_we=0, count=0, mem_addr=BASE_ADDR, err=0.
